// File: rtl/regfile_scoreboard_ctrl_if.sv
// Shared operand-read port: RS and LSB requests with combinational grants, one registered response.
interface regfile_scoreboard_ctrl_if #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
);
  logic             rs_req_valid;
  logic [4:0]       rs_rs1;
  logic [4:0]       rs_rs2;
  logic             rs_req_ready;
  logic             lsb_req_valid;
  logic [4:0]       lsb_rs1;
  logic [4:0]       lsb_rs2;
  logic             lsb_req_ready;
  logic             rsp_valid;
  logic             rsp_to_lsb;
  logic [XLEN-1:0]  vj;
  logic [XLEN-1:0]  vk;
  logic [ROB_W-1:0] qj;
  logic [ROB_W-1:0] qk;
  logic             qj_busy;
  logic             qk_busy;

  modport slave (
    input  rs_req_valid, rs_rs1, rs_rs2, lsb_req_valid, lsb_rs1, lsb_rs2,
    output rs_req_ready, lsb_req_ready, rsp_valid, rsp_to_lsb,
    output vj, vk, qj, qk, qj_busy, qk_busy
  );

  modport master (
    output rs_req_valid, rs_rs1, rs_rs2, lsb_req_valid, lsb_rs1, lsb_rs2,
    input  rs_req_ready, lsb_req_ready, rsp_valid, rsp_to_lsb,
    input  vj, vk, qj, qk, qj_busy, qk_busy
  );
endinterface

// File: rtl/regfile_scoreboard_ctrl.sv
// Register file + busy/rely scoreboard; one RS/LSB operand read per cycle, response 1 cycle after grant.
// Requests wait while unranted; rdy_in=0 freezes everything. COMMIT_BYPASS_EN forwards same-cycle commits to reads.
module regfile_scoreboard_ctrl #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  regfile_scoreboard_ctrl_if.slave rd_bus,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [ROB_W-1:0]         issue_tag,
  input  logic                     commit_valid,
  input  logic [4:0]               commit_rd,
  input  logic [ROB_W-1:0]         commit_tag,
  input  logic [XLEN-1:0]          commit_data,
  input  logic                     flush_in
);

  typedef enum logic {RR_RS = 1'b0, RR_LSB = 1'b1} rr_e;

  rr_e              rr_q, rr_d;
  logic [XLEN-1:0]  data_q [32];
  logic [ROB_W-1:0] rely_q [32];
  logic [31:0]      busy_q, busy_d;

  logic             grant_rs, grant_lsb, grant_any;
  logic             issue_we, commit_we, commit_clr;

  logic [4:0]       src_id   [2];
  logic [XLEN-1:0]  src_val  [2];
  logic [ROB_W-1:0] src_tag  [2];
  logic             src_busy [2];

  logic             rsp_valid_q, rsp_to_lsb_q;
  logic [XLEN-1:0]  vj_q, vk_q;
  logic [ROB_W-1:0] qj_q, qk_q;
  logic             qj_busy_q, qk_busy_q;

  // Arbiter: the pointer only moves after a two-way contest, so a lone requester never steals a turn.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rr_q <= RR_RS;
    else        rr_q <= rr_d;
  end

  always_comb begin
    grant_rs  = 1'b0;
    grant_lsb = 1'b0;
    rr_d      = rr_q;
    if (rdy_in && !flush_in) begin
      if (rd_bus.rs_req_valid && rd_bus.lsb_req_valid) begin
        if (rr_q == RR_RS) begin
          grant_rs = 1'b1;
          rr_d     = RR_LSB;
        end else begin
          grant_lsb = 1'b1;
          rr_d      = RR_RS;
        end
      end else if (rd_bus.rs_req_valid) begin
        grant_rs = 1'b1;
      end else if (rd_bus.lsb_req_valid) begin
        grant_lsb = 1'b1;
      end
    end
  end

  assign grant_any            = grant_rs | grant_lsb;
  assign rd_bus.rs_req_ready  = grant_rs;
  assign rd_bus.lsb_req_ready = grant_lsb;

  // Operand lookup sees pre-update scoreboard state; same-cycle issue is deliberately invisible.
  always_comb begin
    src_id[0] = grant_lsb ? rd_bus.lsb_rs1 : rd_bus.rs_rs1;
    src_id[1] = grant_lsb ? rd_bus.lsb_rs2 : rd_bus.rs_rs2;
    for (int s = 0; s < 2; s++) begin
      src_val[s]  = '0;
      src_tag[s]  = '0;
      src_busy[s] = 1'b0;
      if (src_id[s] != 5'd0) begin
        src_val[s]  = data_q[src_id[s]];
        src_tag[s]  = rely_q[src_id[s]];
        src_busy[s] = busy_q[src_id[s]];
`ifdef COMMIT_BYPASS_EN
        if (commit_valid && (commit_rd == src_id[s]) &&
            (!busy_q[src_id[s]] || (rely_q[src_id[s]] == commit_tag))) begin
          src_val[s]  = commit_data;
          src_busy[s] = 1'b0;
        end
`endif
      end
    end
  end

  assign issue_we   = issue_valid && (issue_rd != 5'd0);
  assign commit_we  = commit_valid && (commit_rd != 5'd0);
  assign commit_clr = commit_we && (rely_q[commit_rd] == commit_tag);

  // Issue is applied after commit so a same-register rename keeps the entry busy.
  always_comb begin
    busy_d = busy_q;
    if (flush_in) begin
      busy_d = '0;
    end else begin
      if (commit_clr) busy_d[commit_rd] = 1'b0;
      if (issue_we)   busy_d[issue_rd]  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < 32; r++) begin
        data_q[r] <= '0;
        rely_q[r] <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      if (commit_we)             data_q[commit_rd] <= commit_data;
      if (issue_we && !flush_in) rely_q[issue_rd]  <= issue_tag;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsp_valid_q  <= 1'b0;
      rsp_to_lsb_q <= 1'b0;
      vj_q         <= '0;
      vk_q         <= '0;
      qj_q         <= '0;
      qk_q         <= '0;
      qj_busy_q    <= 1'b0;
      qk_busy_q    <= 1'b0;
    end else if (rdy_in) begin
      rsp_valid_q <= grant_any;
      if (grant_any) begin
        rsp_to_lsb_q <= grant_lsb;
        vj_q         <= src_val[0];
        vk_q         <= src_val[1];
        qj_q         <= src_tag[0];
        qk_q         <= src_tag[1];
        qj_busy_q    <= src_busy[0];
        qk_busy_q    <= src_busy[1];
      end
    end
  end

  assign rd_bus.rsp_valid  = rsp_valid_q;
  assign rd_bus.rsp_to_lsb = rsp_to_lsb_q;
  assign rd_bus.vj         = vj_q;
  assign rd_bus.vk         = vk_q;
  assign rd_bus.qj         = qj_q;
  assign rd_bus.qk         = qk_q;
  assign rd_bus.qj_busy    = qj_busy_q;
  assign rd_bus.qk_busy    = qk_busy_q;

endmodule
